hash_cmd_queue: RTL and testbench
=================================

Name: hash_cmd_queue

Overview:
- Command-side buffering stage directly upstream of the hash-table AXI-style wrapper.
- Accepts 32-bit command words {op[1:0], key, data} from the host stream and stores them in an in-order FIFO.
- Discards NOP words (op=00).
- Presents the buffered commands to the table with valid/ready, so host bursts never stall on table back-pressure until the queue fills.

Parameters:
- KEY_WIDTH, 6, key field width.
- DATA_WIDTH, 24, payload field width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- WORD_WIDTH, 2+KEY_WIDTH+DATA_WIDTH (32), derived; not overridden.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_i  in  WORD_WIDTH  host command: [31:30] op (10 insert, 11 delete, 01 lookup, 00 NOP), [29:24] key, [23:0] data.
- valid_i  in  1  host word valid.
- ready_o  out  1  queue can accept a word.
- data_o  out  WORD_WIDTH  head command to table.
- valid_o  out  1  head command valid.
- ready_i  in  1  table accepts head command.
- flush_i  in  1  synchronous clear of all queued entries.
- level_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, level_o=0, valid_o=0, ready_o=0, data_o=0. Storage contents are don't-care.
- First rising edge after reset deasserts: ready_o=1.
- Input handshake: a word is taken when valid_i&&ready_o at the edge.
  - op!=00: written at wr_ptr; wr_ptr increments modulo DEPTH.
  - op==00: handshake completes but nothing is written.
- Output handshake: pop when valid_o&&ready_i. rd_ptr increments modulo DEPTH.
- valid_o = (level!=0). data_o = mem[rd_ptr].
- Latency: a word accepted at edge N appears on data_o with valid_o=1 after edge N, provided the queue was empty. No combinational path from data_i/valid_i to data_o/valid_o.
- ready_o is a register, with no combinational path from ready_i. It is 1 iff the post-edge level < DEPTH.
- Pointers are $clog2(DEPTH)+1 bits wide; full/empty is taken from the MSB compare.
- Level update: +1 for a non-NOP push, −1 for a pop, unchanged when both or neither occur.
- Full (level=DEPTH): ready_o=0, no push. A pop in the same cycle frees a slot: ready_o=1 next cycle, not the same cycle.
- Empty: valid_o=0. ready_i is ignored. Push and pop never coincide on an empty queue.
- Simultaneous push+pop with 0<level<DEPTH: both happen, level unchanged, ordering preserved.
- Order: strict FIFO; commands are never reordered or merged (insert/delete/lookup sequencing matters to the table).
- flush_i=1 at an edge:
  - Pointers and level go to 0; valid_o=0 next cycle.
  - Any concurrent push or pop in that cycle is discarded.
  - ready_o=1 next cycle.
  - flush_i overrides everything except reset.
- Reset mid-operation: all entries lost immediately; outputs take their reset values asynchronously.
- Holding rule: data_o is stable while valid_o=1 and ready_i=0.

Optional Feature:
- Macro: HASH_CMD_QUEUE_STATS_EN.
- Defined: adds 16-bit saturating counters ins_cnt_o, del_cnt_o, lkp_cnt_o, nop_cnt_o.
  - Each increments on an accepted input word of that op.
  - Each holds at 16'hFFFF once reached.
  - Cleared by reset and by flush_i.
  - Output ports exist only when defined.
- Undefined: no counters, no extra ports, core behaviour identical.

Test Plan:
- Reset then idle: after reset rises, ready_o=1, valid_o=0, level_o=0. Asserting reset=0 mid-stream drops valid_o to 0 without waiting for a clock edge.
- Burst in order: push {10,000000,1}, {10,001000,a}, {11,001000,0}, {01,001000,ff} with ready_i=1 → data_o delivers the same four words in order, each one cycle after acceptance; level_o never exceeds 1.
- Fill and back-pressure: ready_i=0, push 9 inserts keys 0..8 → level_o=8, ready_o=0 after the 8th; the 9th is not taken. Set ready_i=1 for one cycle → key 0 popped, ready_o=1 the next cycle, and the 9th word is then accepted.
- NOP filtering: push {00,000111,5} between two inserts → only the two inserts appear at data_o; level_o peaks at 2. With the macro defined, nop_cnt_o=1 and ins_cnt_o=2.
- Flush with concurrent traffic: level=3, assert flush_i together with valid_i=1 and ready_i=1 → next cycle level_o=0, valid_o=0; the concurrent word is not stored.
- Wrap-around: 20 push/pop cycles with ready_i toggling every cycle → output sequence exactly equals input sequence, pointers wrap past DEPTH, no loss or duplication.

Source files
------------

// File: rtl/hash_cmd_queue.sv
// hash_cmd_queue: in-order command FIFO ahead of the hash-table wrapper; NOP words are dropped.
// Optional per-op saturating counters are enabled by defining HASH_CMD_QUEUE_STATS_EN.
`default_nettype none

module hash_cmd_queue #(
  parameter  int KEY_WIDTH  = 6,
  parameter  int DATA_WIDTH = 24,
  parameter  int DEPTH      = 8,
  localparam int WORD_WIDTH = 2 + KEY_WIDTH + DATA_WIDTH,
  localparam int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  flush_i,
`ifdef HASH_CMD_QUEUE_STATS_EN
  output logic [15:0]           ins_cnt_o,
  output logic [15:0]           del_cnt_o,
  output logic [15:0]           lkp_cnt_o,
  output logic [15:0]           nop_cnt_o,
`endif
  output logic [PTR_WIDTH-1:0]  level_o
);

  localparam int ADDR_WIDTH = PTR_WIDTH - 1;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  level_nxt;
  logic [1:0]            op_in;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full;

  assign op_in = data_i[WORD_WIDTH-1 -: 2];

  // Extra MSB on each pointer separates the full and empty cases when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign accept = valid_i && ready_o;
  assign push   = accept && (op_in != 2'b00) && !full && !flush_i;
  assign pop    = !empty && ready_i && !flush_i;

  assign level_o   = wr_ptr - rd_ptr;
  assign level_nxt = level_o + PTR_WIDTH'(push) - PTR_WIDTH'(pop);

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_o <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Registered so the host side never sees a combinational path from ready_i.
      ready_o <= (level_nxt < PTR_WIDTH'(DEPTH));
    end
  end

`ifdef HASH_CMD_QUEUE_STATS_EN
  logic [15:0] cnt [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (accept && (cnt[op_in] != 16'hFFFF)) begin
      cnt[op_in] <= cnt[op_in] + 16'd1;
    end
  end

  assign nop_cnt_o = cnt[0];
  assign lkp_cnt_o = cnt[1];
  assign ins_cnt_o = cnt[2];
  assign del_cnt_o = cnt[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_hash_cmd_queue.sv
// Bench for hash_cmd_queue: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps

module tb_hash_cmd_queue;
  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic [3:0]   level_o;
`ifdef HASH_CMD_QUEUE_STATS_EN
  logic [15:0]  ins_cnt_o, del_cnt_o, lkp_cnt_o, nop_cnt_o;
  int           m_cnt [4];
`endif

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] q [$];
  bit           m_ready = 1'b0;

  hash_cmd_queue dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i),
`ifdef HASH_CMD_QUEUE_STATS_EN
    .ins_cnt_o(ins_cnt_o), .del_cnt_o(del_cnt_o), .lkp_cnt_o(lkp_cnt_o), .nop_cnt_o(nop_cnt_o),
`endif
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cmd(input logic [1:0] op, input logic [5:0] key,
                                       input logic [23:0] dat);
    return {op, key, dat};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_o", W'(valid_o), W'(q.size() != 0));
    chk("data_o",  data_o, (q.size() != 0) ? q[0] : '0);
    chk("level_o", W'(level_o), W'(q.size()));
    chk("ready_o", W'(ready_o), W'(m_ready));
`ifdef HASH_CMD_QUEUE_STATS_EN
    chk("nop_cnt", W'(nop_cnt_o), W'(m_cnt[0]));
    chk("lkp_cnt", W'(lkp_cnt_o), W'(m_cnt[1]));
    chk("ins_cnt", W'(ins_cnt_o), W'(m_cnt[2]));
    chk("del_cnt", W'(del_cnt_o), W'(m_cnt[3]));
`endif
  endtask

  // What the queue should hold after the coming rising edge.
  task automatic model_edge(input bit v, input logic [W-1:0] w, input bit r, input bit f);
    bit acc;
    bit pop;
    acc = v && m_ready;
    pop = (q.size() != 0) && r;
    if (f) begin
      q.delete();
      m_ready = 1'b1;
`ifdef HASH_CMD_QUEUE_STATS_EN
      foreach (m_cnt[i]) m_cnt[i] = 0;
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && w[31:30] != 2'b00) q.push_back(w);
      m_ready = (q.size() < DEPTH);
`ifdef HASH_CMD_QUEUE_STATS_EN
      if (acc && m_cnt[w[31:30]] < 16'hFFFF) m_cnt[w[31:30]]++;
`endif
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
`ifdef HASH_CMD_QUEUE_STATS_EN
    foreach (m_cnt[i]) m_cnt[i] = 0;
`endif
  endtask

  task automatic step(input bit v, input logic [W-1:0] w, input bit r, input bit f);
    @(negedge clk);
    check_all();
    valid_i = v;
    data_i  = w;
    ready_i = r;
    flush_i = f;
    model_edge(v, w, r, f);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", W'(q.size()), '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    check_all();
    model_edge(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    release_reset();
    step(1'b0, '0, 1'b0, 1'b0);

    // Burst with the table always ready.
    step(1'b1, cmd(2'b10, 6'o00, 24'h1),  1'b1, 1'b0);
    step(1'b1, cmd(2'b10, 6'o10, 24'ha),  1'b1, 1'b0);
    step(1'b1, cmd(2'b11, 6'o10, 24'h0),  1'b1, 1'b0);
    step(1'b1, cmd(2'b01, 6'o10, 24'hff), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill under back-pressure; the 9th insert waits until one slot is freed.
    for (int k = 0; k < 9; k++) step(1'b1, cmd(2'b10, 6'(k), 24'(k + 100)), 1'b0, 1'b0);
    chk("full_level", W'(level_o), W'(DEPTH));
    chk("full_ready", W'(ready_o), '0);
    step(1'b1, cmd(2'b10, 6'd8, 24'd108), 1'b1, 1'b0);
    step(1'b1, cmd(2'b10, 6'd8, 24'd108), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("refill_level", W'(level_o), W'(DEPTH));
    drain();

    // NOP between two inserts never reaches the table.
    step(1'b1, cmd(2'b10, 6'd1, 24'h11), 1'b0, 1'b0);
    step(1'b1, cmd(2'b00, 6'o07, 24'h5), 1'b0, 1'b0);
    step(1'b1, cmd(2'b10, 6'd2, 24'h22), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("nop_level", W'(level_o), 32'd2);
    drain();

    // Flush with a concurrent push and pop.
    for (int k = 0; k < 3; k++) step(1'b1, cmd(2'b11, 6'(k), 24'(k)), 1'b0, 1'b0);
    step(1'b1, cmd(2'b10, 6'd9, 24'h99), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_level", W'(level_o), '0);
    chk("flush_valid", W'(valid_o), '0);

    // Wrap-around with the table toggling ready every cycle.
    for (int k = 0; k < 20; k++) step(1'b1, cmd(2'b01, 6'(k), 24'($urandom)), 1'(k % 2), 1'b0);
    drain();

    // Randomized traffic including NOPs and occasional flushes.
    for (int k = 0; k < 400; k++)
      step(($urandom % 4) != 0, $urandom, 1'($urandom), ($urandom % 50) == 0);

    // Asynchronous reset in the middle of traffic.
    step(1'b1, cmd(2'b10, 6'd3, 24'h3), 1'b0, 1'b0);
    step(1'b1, cmd(2'b10, 6'd4, 24'h4), 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_valid", W'(valid_o), '0);
    chk("async_level", W'(level_o), '0);
    chk("async_ready", W'(ready_o), '0);
    chk("async_data",  data_o, '0);
    release_reset();
    step(1'b1, cmd(2'b11, 6'd5, 24'h5), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
